// File: rtl/msg_schedule_stream.sv
// Streaming SHA-2 message-schedule expander: 16-word sliding window, one W[t] per cycle.
// Optional downstream back-pressure (wt_ready) is enabled by defining MSG_SCHED_STALL_EN.
module msg_schedule_stream #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [16*WORD_W-1:0]       blk_data,
  output logic                       wt_valid,
`ifdef MSG_SCHED_STALL_EN
  input  logic                       wt_ready,
`endif
  output logic [WORD_W-1:0]          wt_data,
  output logic [$clog2(ROUNDS)-1:0]  wt_index,
  output logic                       wt_last,
  output logic                       busy
);
  localparam int IDX_W = $clog2(ROUNDS);
  localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);
  localparam bit W64 = (WORD_W == 64);
  localparam int S0A = W64 ? 1  : 7;
  localparam int S0B = W64 ? 8  : 18;
  localparam int S0C = W64 ? 7  : 3;
  localparam int S1A = W64 ? 19 : 17;
  localparam int S1B = W64 ? 61 : 19;
  localparam int S1C = W64 ? 6  : 10;

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("msg_schedule_stream: WORD_W must be 32 or 64");
  end
  if (ROUNDS < 16) begin : g_bad_rounds
    $error("msg_schedule_stream: ROUNDS must be >= 16");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   r_state, w_state_nxt;
  logic [15:0][WORD_W-1:0]  r_win;
  logic [IDX_W-1:0]         r_t;
  logic                     w_accept, w_beat, w_rdy, w_last_t;
  logic [WORD_W-1:0]        w_s0, w_s1, w_new;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

`ifdef MSG_SCHED_STALL_EN
  assign w_rdy = wt_ready;
`else
  assign w_rdy = 1'b1;
`endif

  // window[0]=W[t-16], window[1]=W[t-15], window[9]=W[t-7], window[14]=W[t-2]
  assign w_s0     = ror(r_win[1], S0A) ^ ror(r_win[1], S0B) ^ (r_win[1] >> S0C);
  assign w_s1     = ror(r_win[14], S1A) ^ ror(r_win[14], S1B) ^ (r_win[14] >> S1C);
  assign w_new    = w_s1 + r_win[9] + w_s0 + r_win[0];
  assign w_last_t = (r_t == LAST_T);

  always_comb begin
    w_state_nxt = r_state;
    blk_ready   = 1'b0;
    w_accept    = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      IDLE: begin
        blk_ready = !reset;
        w_accept  = blk_valid && !reset;
        if (w_accept) w_state_nxt = RUN;
      end
      RUN: begin
        w_beat = w_rdy;
        if (w_beat && w_last_t) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        for (int i = 0; i < 16; i++) r_win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
        r_t <= '0;
      end else if (w_beat) begin
        r_win <= {w_new, r_win[15:1]};
        r_t   <= w_last_t ? '0 : r_t + 1'b1;
      end
    end
  end

  assign wt_valid = (r_state == RUN);
  assign busy     = (r_state == RUN);
  assign wt_data  = r_win[0];
  assign wt_index = r_t;
  assign wt_last  = (r_state == RUN) && w_last_t;

endmodule

// File: tb/tb_msg_schedule_stream.sv
// Scoreboard bench for msg_schedule_stream: SHA-256 and SHA-512 instances, directed blocks.
module tb_msg_schedule_stream;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  typedef struct {logic [63:0] data; int idx; bit last;} exp_t;
  exp_t q32[$];
  exp_t q64[$];
  logic [63:0] got32[64];
  logic [63:0] got64[80];
  int n_cmp = 0;
  int n_bad = 0;

  logic         bv32 = 1'b0, bv64 = 1'b0, rdy32 = 1'b1, rdy64 = 1'b1;
  logic [511:0] bd32 = '0;
  logic [1023:0] bd64 = '0;
  logic         br32, wv32, wl32, by32, br64, wv64, wl64, by64;
  logic [31:0]  wd32;
  logic [63:0]  wd64;
  logic [5:0]   wi32;
  logic [6:0]   wi64;

  msg_schedule_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (
    .clock(clock), .reset(reset), .blk_valid(bv32), .blk_ready(br32), .blk_data(bd32),
    .wt_valid(wv32),
`ifdef MSG_SCHED_STALL_EN
    .wt_ready(rdy32),
`endif
    .wt_data(wd32), .wt_index(wi32), .wt_last(wl32), .busy(by32));

  msg_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (
    .clock(clock), .reset(reset), .blk_valid(bv64), .blk_ready(br64), .blk_data(bd64),
    .wt_valid(wv64),
`ifdef MSG_SCHED_STALL_EN
    .wt_ready(rdy64),
`endif
    .wt_data(wd64), .wt_index(wi64), .wt_last(wl64), .busy(by64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout/unexpected want expected event", nm);
  endtask

  // Reference schedule in the textbook W[t-2],W[t-7],W[t-15],W[t-16] form.
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  task automatic push32(input logic [511:0] b);
    logic [31:0] w[64];
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = b[511-32*t -: 32];
      else w[t] = s1_32(w[t-2]) + w[t-7] + s0_32(w[t-15]) + w[t-16];
      q32.push_back('{data: {32'h0, w[t]}, idx: t, last: (t == 63)});
    end
  endtask

  task automatic push64(input logic [1023:0] b);
    logic [63:0] w[80];
    for (int t = 0; t < 80; t++) begin
      if (t < 16) w[t] = b[1023-64*t -: 64];
      else w[t] = s1_64(w[t-2]) + w[t-7] + s0_64(w[t-15]) + w[t-16];
      q64.push_back('{data: w[t], idx: t, last: (t == 79)});
    end
  endtask

  // Holds blk_valid high with junk data until ready, then presents d for the accept edge.
  task automatic send(input bit sel, input logic [1023:0] d, output int n);
    n = 0;
    if (sel) bv64 = 1'b1; else bv32 = 1'b1;
    while (!(sel ? br64 : br32) && n < 200) begin
      if (sel) bd64 = {$urandom, $urandom, d[959:0]}; else bd32 = {$urandom, d[479:0]};
      @(posedge clock); #1; n++;
    end
    if (n >= 200) begin
      fail(sel ? "send64_ready" : "send32_ready");
    end else begin
      if (sel) bd64 = d; else bd32 = d[511:0];
      @(posedge clock); #1; n++;
      if (sel) push64(d); else push32(d[511:0]);
    end
    if (sel) bv64 = 1'b0; else bv32 = 1'b0;
  endtask

  task automatic drain(input bit sel);
    int k = 0;
    while ((sel ? q64.size() : q32.size()) != 0 && k < 400) begin
      @(posedge clock); #1; k++;
    end
    if (k >= 400) fail(sel ? "drain64" : "drain32");
  endtask

  always @(negedge clock) begin : mon32
    exp_t e;
    if (wv32) begin
      if (q32.size() == 0) fail("w32_unexpected_valid");
      else begin
        e = q32[0];
        chk($sformatf("w32_data[%0d]", e.idx), {32'h0, wd32}, e.data);
        chk("w32_index", {58'h0, wi32}, e.idx);
        chk("w32_last", {63'h0, wl32}, {63'h0, e.last});
        if (rdy32) begin
          got32[e.idx] = {32'h0, wd32};
          void'(q32.pop_front());
        end
      end
    end
  end

  always @(negedge clock) begin : mon64
    exp_t e;
    if (wv64) begin
      if (q64.size() == 0) fail("w64_unexpected_valid");
      else begin
        e = q64[0];
        chk($sformatf("w64_data[%0d]", e.idx), wd64, e.data);
        chk("w64_index", {57'h0, wi64}, e.idx);
        chk("w64_last", {63'h0, wl64}, {63'h0, e.last});
        if (rdy64) begin
          got64[e.idx] = wd64;
          void'(q64.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] abc32, abc64, inc32, zero;
    int n, c, nv;
    abc32 = {512'h0, 32'h61626380, {14{32'h0}}, 32'h00000018};
    abc64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
    zero  = '0;
    inc32 = '0;
    for (int i = 0; i < 16; i++) inc32[511-32*i -: 32] = 32'h0101_0101 * (i + 1);

    // reset state
    repeat (3) @(posedge clock); #1;
    chk("rst_wt_valid", {63'h0, wv32}, 64'h0);
    chk("rst_busy", {63'h0, by32}, 64'h0);
    chk("rst_wt_index", {58'h0, wi32}, 64'h0);
    chk("rst_wt_last", {63'h0, wl32}, 64'h0);
    chk("rst_wt_data", {32'h0, wd32}, 64'h0);
    chk("rst_blk_ready", {63'h0, br32}, 64'h0);
    reset = 1'b0; #1;
    chk("post_rst_blk_ready", {63'h0, br32}, 64'h1);

    // SHA-256 "abc"
    send(0, abc32, n);
    drain(0);
    chk("abc_W0", got32[0], 64'h61626380);
    chk("abc_W15", got32[15], 64'h00000018);
    chk("abc_W16", got32[16], 64'h61626380);
    chk("abc_W17", got32[17], 64'h000F0000);
    chk("abc_W18", got32[18], 64'h7DA86405);

    // all-zero block: valid window and block period
    @(posedge clock); #1;
    send(0, zero, n);
    nv = 0;
    for (c = 1; c <= 100; c++) begin
      @(negedge clock);
      if (wv32) nv++;
      if (br32) break;
    end
    chk("zero_valid_cycles", 64'(nv), 64'd64);
    chk("zero_ready_cycle", 64'(c), 64'd65);
    drain(0);

    // back-to-back: blk_valid held with junk data during RUN
    send(0, inc32, n);
    chk("b2b_first_wait", 64'(n), 64'd1);
    send(0, abc32, n);
    chk("b2b_period", 64'(n), 64'd65);
    drain(0);

`ifdef MSG_SCHED_STALL_EN
    send(0, inc32, n);
    repeat (5) @(posedge clock); #1;
    rdy32 = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("stall_index_held", {58'h0, wi32}, 64'd5);
    rdy32 = 1'b1;
    drain(0);
`endif

    // reset during RUN at t=20
    send(0, abc32, n);
    repeat (20) @(posedge clock); #1;
    chk("pre_rst_index", {58'h0, wi32}, 64'd20);
    reset = 1'b1;
    @(posedge clock); #1;
    q32.delete();
    chk("midrst_wt_valid", {63'h0, wv32}, 64'h0);
    chk("midrst_busy", {63'h0, by32}, 64'h0);
    reset = 1'b0; #1;
    chk("midrst_blk_ready", {63'h0, br32}, 64'h1);
    send(0, inc32, n);
    drain(0);
    chk("fresh_W0", got32[0], 64'h01010101);

    // SHA-512 "abc"
    send(1, abc64, n);
    drain(1);
    chk("abc512_W0", got64[0], 64'h6162638000000000);
    chk("abc512_W15", got64[15], 64'h18);
    chk("abc512_W16", got64[16], 64'h6162638000000000);
    chk("abc512_W17", got64[17], 64'h00030000000000C0);
    @(posedge clock); #1;
    chk("abc512_idle", {63'h0, by64}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
